// File: rtl/strt_validator.sv
// strt_validator: start-bit detector for the UART receiver. Falling edge, three-sample majority vote, busy lockout, saturating glitch counter.
// Optional two-flop input synchronizer: define STRT_CHK_SYNC_EN.
module strt_validator #(
  parameter int PS_W  = 6,
  parameter int CNT_W = 8
) (
  input  logic             strt_check_clk,
  input  logic             strt_check_rst,
  input  logic             rx_in,
  input  logic             strt_chk_en,
  input  logic [PS_W-1:0]  prescale,
  input  logic             frame_done,
  input  logic             glitch_cnt_clr,
  output logic             strt_valid,
  output logic             strt_glitch,
  output logic             strt_busy,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic [1:0]       strt_state_dbg
);
  // Handshake: strt_valid and strt_glitch are single-cycle, mutually exclusive pulses with no ready.
  // strt_busy holds from the strt_valid cycle until the cycle after frame_done.
  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, BUSY = 2'd2} state_e;

  localparam logic [PS_W-1:0]  PS_MIN  = PS_W'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q;
  logic             rx_s;
  logic             prev_q;
  logic             s_lo_q;
  logic             s_mid_q;
  logic [PS_W-1:0]  tick_q;
  logic [PS_W-1:0]  ps_l_q;
  logic             valid_q;
  logic             glitch_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic [PS_W-1:0]  half_d;
  logic [PS_W-1:0]  ps_d;
  logic [CNT_W-1:0] cnt_d;
  logic             edge_d;
  logic             abort_d;
  logic             decide_d;
  logic             vote_lo_d;
  logic             glitch_d;

`ifdef STRT_CHK_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge strt_check_clk or negedge strt_check_rst) begin
    if (!strt_check_rst) sync_q <= 2'b11;
    else                 sync_q <= {sync_q[0], rx_in};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  always_comb begin
    half_d    = ps_l_q >> 1;
    ps_d      = (prescale < PS_MIN) ? PS_MIN : prescale;
    edge_d    = (state_q == IDLE) && strt_chk_en && prev_q && !rx_s;
    abort_d   = (state_q == SAMPLE) && !strt_chk_en;
    decide_d  = (state_q == SAMPLE) && strt_chk_en && (tick_q == half_d + PS_W'(1));
    // Live sample at H+1 votes alongside the two captured ones.
    vote_lo_d = (!s_lo_q && !s_mid_q) || (!s_lo_q && !rx_s) || (!s_mid_q && !rx_s);
    glitch_d  = decide_d && !vote_lo_d;
    cnt_d     = cnt_q;
    if (glitch_cnt_clr)                      cnt_d = glitch_d ? CNT_W'(1) : '0;
    else if (glitch_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge strt_check_clk or negedge strt_check_rst) begin
    if (!strt_check_rst) begin
      state_q  <= IDLE;
      prev_q   <= 1'b1;
      s_lo_q   <= 1'b1;
      s_mid_q  <= 1'b1;
      tick_q   <= '0;
      ps_l_q   <= PS_MIN;
      valid_q  <= 1'b0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= rx_s;
      valid_q  <= 1'b0;
      glitch_q <= 1'b0;
      cnt_q    <= cnt_d;
      case (state_q)
        IDLE: begin
          if (edge_d) begin
            state_q <= SAMPLE;
            tick_q  <= PS_W'(1);
            ps_l_q  <= ps_d;
          end
        end
        SAMPLE: begin
          tick_q <= tick_q + PS_W'(1);
          if (tick_q == half_d - PS_W'(1)) s_lo_q  <= rx_s;
          if (tick_q == half_d)            s_mid_q <= rx_s;
          if (abort_d) begin
            state_q <= IDLE;
            tick_q  <= '0;
          end else if (decide_d) begin
            tick_q   <= '0;
            valid_q  <= vote_lo_d;
            glitch_q <= !vote_lo_d;
            busy_q   <= vote_lo_d;
            state_q  <= vote_lo_d ? BUSY : IDLE;
          end
        end
        BUSY: begin
          if (frame_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign strt_valid     = valid_q;
  assign strt_glitch    = glitch_q;
  assign strt_busy      = busy_q;
  assign glitch_cnt     = cnt_q;
  assign strt_state_dbg = state_q;
endmodule

// File: tb/tb_strt_validator.sv
// Bench for strt_validator: directed and random segments, each started from reset, checked cycle by cycle
// against a trace-scanning reference model.
module tb_strt_validator;
  localparam int PS_W  = 6;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int MAXL  = 512;
  localparam int W     = 3 + CNT_W;
`ifdef STRT_CHK_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx    = 1'b1;
  logic            en    = 1'b0;
  logic            fd    = 1'b0;
  logic            clr   = 1'b0;
  logic [PS_W-1:0] ps    = PS_W'(8);
  logic            v;
  logic            g;
  logic            b;
  logic [CNT_W-1:0] c;
  logic [1:0]      dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic rx_a[MAXL];
  logic en_a[MAXL];
  logic fd_a[MAXL];
  logic clr_a[MAXL];
  int   ps_a[MAXL];
  int   wp = 0;
  logic [W-1:0] obs_a[MAXL];
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  strt_validator #(.PS_W(PS_W), .CNT_W(CNT_W)) dut (
    .strt_check_clk (clk),
    .strt_check_rst (rst_n),
    .rx_in          (rx),
    .strt_chk_en    (en),
    .prescale       (ps),
    .frame_done     (fd),
    .glitch_cnt_clr (clr),
    .strt_valid     (v),
    .strt_glitch    (g),
    .strt_busy      (b),
    .glitch_cnt     (c),
    .strt_state_dbg (dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks: build a per-cycle stimulus trace
  task automatic push(input logic r, input logic e, input logic f, input int p);
    if (wp < MAXL) begin
      rx_a[wp] = r; en_a[wp] = e; fd_a[wp] = f; clr_a[wp] = 1'b0; ps_a[wp] = p;
      wp++;
    end
  endtask

  task automatic push_n(input logic r, input int n, input int p);
    repeat (n) push(r, 1'b1, 1'b0, p);
  endtask

  task automatic gen_random(input int len);
    logic cur;
    int   run;
    int   p;
    cur = 1'b1; run = 3; p = 8;
    for (int i = 0; i < len; i++) begin
      if (run == 0) begin
        cur = !cur;
        run = cur ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 40));
        case ($urandom_range(0, 4))
          0: p = 8;
          1: p = 16;
          2: p = 32;
          3: p = int'($urandom_range(0, 7));
          default: ;
        endcase
      end
      run--;
      push(cur ^ ($urandom_range(0, 11) == 0), $urandom_range(0, 59) != 0,
           $urandom_range(0, 9) == 0, p);
      clr_a[wp-1] = ($urandom_range(0, 59) == 0);
    end
  endtask

  // reference model: scan the line trace for start episodes
  function automatic void model(input int len);
    logic rxs[MAXL];
    logic ev[MAXL];
    logic eg[MAXL];
    logic eb[MAXL];
    int   ec[MAXL];
    int   t, e, h, d, a, f, zeros;
    logic prv;
    for (int i = 0; i < len; i++) begin
      if (i >= SD) rxs[i] = rx_a[i-SD];
      else         rxs[i] = 1'b1;
      ev[i] = 1'b0; eg[i] = 1'b0; eb[i] = 1'b0;
    end
    t = 0;
    while (t < len) begin
      if (t == 0) prv = 1'b1;
      else        prv = rxs[t-1];
      if (!(en_a[t] && prv && !rxs[t])) begin
        t++;
        continue;
      end
      e = t;
      h = ((ps_a[e] < 4) ? 4 : ps_a[e]) / 2;
      d = e + h + 2;
      a = -1;
      for (int k = e + 1; k <= e + h + 1 && k < len; k++)
        if (!en_a[k] && a < 0) a = k;
      if (a >= 0) begin
        t = a + 1;
        continue;
      end
      if (e + h + 1 >= len) break;
      zeros = int'(!rxs[e+h-1]) + int'(!rxs[e+h]) + int'(!rxs[e+h+1]);
      if (zeros >= 2) begin
        if (d < len) ev[d] = 1'b1;
        f = d;
        while (f < len) begin
          eb[f] = 1'b1;
          if (fd_a[f]) break;
          f++;
        end
        t = f + 1;
      end else begin
        if (d < len) eg[d] = 1'b1;
        t = d;
      end
    end
    ec[0] = 0;
    for (int i = 1; i < len; i++) begin
      if (clr_a[i-1])                 ec[i] = eg[i] ? 1 : 0;
      else if (eg[i] && ec[i-1] < CMAX) ec[i] = ec[i-1] + 1;
      else                            ec[i] = ec[i-1];
    end
    for (int i = 0; i < len; i++)
      exp_q.push_back({ev[i], eg[i], eb[i], CNT_W'(ec[i])});
  endfunction

  task automatic do_reset(input string name);
    #1 rst_n = 1'b0;
    #1;
    check({name, ".valid"},  32'(v),   32'd0);
    check({name, ".glitch"}, 32'(g),   32'd0);
    check({name, ".busy"},   32'(b),   32'd0);
    check({name, ".cnt"},    32'(c),   32'd0);
    check({name, ".state"},  32'(dbg), 32'd0);
    rx = 1'b1; en = 1'b0; fd = 1'b0; clr = 1'b0; ps = PS_W'(8);
    @(negedge clk);
    wp = 0;
  endtask

  // scoreboard: apply the trace, then compare against the model's expected queue
  task automatic run_seg(input string name);
    int len;
    logic [W-1:0] ex;
    len = wp;
    model(len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      obs_a[i] = {v, g, b, c};
      rx = rx_a[i]; en = en_a[i]; fd = fd_a[i]; clr = clr_a[i]; ps = PS_W'(ps_a[i]);
    end
    for (int i = 0; i < len; i++) begin
      ex = exp_q.pop_front();
      check($sformatf("%s[%0d].valid", name, i),  32'(obs_a[i][W-1]), 32'(ex[W-1]));
      check($sformatf("%s[%0d].glitch", name, i), 32'(obs_a[i][W-2]), 32'(ex[W-2]));
      check($sformatf("%s[%0d].busy", name, i),   32'(obs_a[i][W-3]), 32'(ex[W-3]));
      check($sformatf("%s[%0d].cnt", name, i),    32'(obs_a[i][CNT_W-1:0]), 32'(ex[CNT_W-1:0]));
    end
    check({name, ".qlen"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int e;
    do_reset("init");

    // clean start at prescale 8, then busy lockout against line toggles, ending in BUSY
    push_n(1, 4, 8); push_n(0, 8, 8); push_n(1, 6, 8); push(1, 1, 1, 8); push_n(1, 3, 8);
    push_n(0, 10, 8);
    repeat (4) begin push(1, 1, 0, 8); push(0, 1, 0, 8); end
    push(1, 1, 1, 8); push_n(1, 5, 8);
    push_n(0, 10, 16); push_n(1, 10, 16);
    run_seg("clean");
    do_reset("rst_busy");

    // prescale 16: short glitch, vote 0/1/0 -> valid, vote 1/0/1 -> glitch
    push_n(1, 3, 16); push_n(0, 3, 16); push_n(1, 16, 16);
    push_n(0, 8, 16); push(1, 1, 0, 16); push(0, 1, 0, 16); push_n(1, 14, 16);
    push(1, 1, 1, 16); push_n(1, 3, 16);
    push_n(0, 7, 16); push(1, 1, 0, 16); push(0, 1, 0, 16); push(1, 1, 0, 16); push_n(1, 14, 16);
    run_seg("vote");
    do_reset("rst_vote");

    // enable dropped at tick 2, then a normal start; prescale below 4 behaves as 4
    push_n(1, 3, 8); e = wp; push_n(0, 8, 8); en_a[e + SD + 2] = 1'b0; push_n(1, 10, 8);
    push_n(0, 8, 8); push_n(1, 8, 8); push(1, 1, 1, 8); push_n(1, 4, 8);
    push_n(0, 6, 2); push_n(1, 8, 2); push(1, 1, 1, 2); push_n(1, 4, 2);
    run_seg("abort");
    do_reset("rst_abort");

    // counter saturation, clear vs increment, plain clear; ends in SAMPLE at tick 3
    push_n(1, 3, 8);
    repeat (5) begin push_n(0, 2, 8); push_n(1, 10, 8); end
    e = wp; push_n(0, 2, 8); push_n(1, 10, 8); clr_a[e + SD + 5] = 1'b1;
    push_n(0, 2, 8); push_n(1, 10, 8);
    e = wp; push_n(1, 4, 8); clr_a[e + 1] = 1'b1;
    push_n(0, 2, 8); push_n(1, 10, 8);
    push_n(0, SD + 4, 16);
    run_seg("count");
    do_reset("rst_sample");

    for (int s = 0; s < 8; s++) begin
      gen_random(300);
      run_seg($sformatf("rnd%0d", s));
      do_reset($sformatf("rst_rnd%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/strt_validator.md
# strt_validator

Parametrised start-bit validator for the UART receiver. It watches the oversampled serial line and detects the falling edge that marks a start bit. It then majority-votes three mid-bit samples and reports either a valid start, which hands off to the deserializer, or a glitch, which re-arms detection. It replaces the single-sample start check, adding runtime prescale, majority voting, a frame-busy lockout and a saturating glitch counter.

## Interface
- PS_W, 6: width of the `prescale` input.
- CNT_W, 8: width of the glitch counter.
- strt_check_clk  in  1  oversampling clock; one cycle = one sample tick.
- strt_check_rst  in  1  reset, asynchronous, active-low.
- rx_in  in  1  serial line; idle high.
- strt_chk_en  in  1  detection enable, level.
- prescale  in  PS_W  oversampling ratio; legal 8/16/32; latched at edge detect.
- frame_done  in  1  one-cycle pulse from the deserializer FSM; ends the busy lockout.
- glitch_cnt_clr  in  1  synchronous clear of `glitch_cnt`.
- strt_valid  out  1  one-cycle pulse: start bit confirmed.
- strt_glitch  out  1  one-cycle pulse: start edge rejected as a glitch.
- strt_busy  out  1  high from the `strt_valid` cycle until the `frame_done` cycle.
- glitch_cnt  out  CNT_W  saturating count of rejected edges.

## Operation
- `rx_s` is the line as seen by the block; see Configuration. `prev` is `rx_s` registered every cycle in all states.
- States:
  - IDLE, reset state.
  - SAMPLE.
  - BUSY.
- IDLE → SAMPLE: on any cycle with `strt_chk_en`=1, `prev`=1 and `rx_s`=0.
  - That cycle is tick 0.
  - `tick` loads 1 for the next cycle.
  - `ps_l` latches `prescale`. Values below 4 latch as 4.
- SAMPLE:
  - `tick` increments each cycle.
  - `rx_s` is captured at ticks H-1, H and H+1, where H = `ps_l`>>1.
- Decision at tick H+1, using the captured H-1 and H samples plus the live H+1 sample:
  - Majority 0 (at least two zeros): assert `strt_valid` next cycle, go to BUSY.
  - Majority 1: assert `strt_glitch` next cycle, increment `glitch_cnt`, go to IDLE.
- SAMPLE abort: if `strt_chk_en`=0 in any SAMPLE cycle, go to IDLE, no pulse, counter unchanged.
- BUSY:
  - `strt_busy`=1.
  - Edges and `strt_chk_en` are ignored.
  - `frame_done`=1 → IDLE on the next cycle. `strt_busy` drops in that same cycle.
  - `frame_done` outside BUSY is ignored.
- Re-arm: a new start needs `prev`=1, so the line must return high for at least one cycle after a glitch or a frame.
- `glitch_cnt`:
  - Saturates at 2^CNT_W-1.
  - `glitch_cnt_clr` alone → 0.
  - Clear coinciding with an increment → 1.
- Reset mid-operation: all state returns immediately to the reset values below. No pulse is generated on reset exit.

## Timing
- Reset values:
  - `strt_valid`=0, `strt_glitch`=0, `strt_busy`=0, `glitch_cnt`=0.
  - State IDLE, `prev`=1, `tick`=0.
  - Synchronizer flops (when compiled in) = 1.
- Edge tick E = first cycle with `rx_s`=0.
- `strt_valid` and `strt_glitch` are high in exactly cycle E+H+2 and are never high together.
- `strt_busy` rises in cycle E+H+2, together with `strt_valid`.
- Examples: `prescale`=8 gives outputs at E+6; `prescale`=16 gives E+10.
- Earliest next detection after a glitch: cycle E+H+2, provided `prev`=1 then.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `STRT_CHK_SYNC_EN` defined: `rx_in` passes through a two-flop synchronizer (reset to 1) before `rx_s`. Edge detection lags the pin by 2 cycles.
- `STRT_CHK_SYNC_EN` undefined: `rx_s` = `rx_in` directly. For use when the line is already synchronous to `strt_check_clk`.

## Test plan
- Clean start, `prescale`=8, enable=1: `rx_s` low for 8 ticks → `strt_valid` pulse at E+6, `strt_busy`=1, `glitch_cnt`=0. Then `frame_done` pulse → `strt_busy`=0, state IDLE.
- Glitch, `prescale`=16: `rx_s` low for 3 ticks, then high → `strt_glitch` pulse at E+10, `glitch_cnt`=1, no `strt_valid`.
- Majority vote, `prescale`=16: samples at ticks 7/8/9 = 0/1/0 → `strt_valid`. Samples = 1/0/1 → `strt_glitch`.
- Abort and lockout:
  - `strt_chk_en` dropped at tick 2 → no pulses, IDLE.
  - In BUSY, line toggles 1→0 → no new detection until `frame_done`.
- Counter, CNT_W=2:
  - 5 glitches → `glitch_cnt`=3 (saturated).
  - Clear coinciding with a glitch decision → `glitch_cnt`=1.
- Reset while in SAMPLE at tick 3 → all outputs 0 immediately, no pulse after release. With `STRT_CHK_SYNC_EN` defined, detection starts 2 cycles after the pin edge.
